serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing o_diff = i_x - i_y - i_borrow, one bit per clock, LSB first.
- Uses a single full-subtractor cell and a registered borrow, so it is the inverse-direction counterpart of the ripple full-adder datapath.
- Intended as the area-minimal subtract unit for the arithmetic blocks, with a start/done handshake toward the controller.

---
 rtl/serial_subtractor.sv | 141 ++++++++++++++
 tb/tb_serial_subtractor.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: o_diff = i_x - i_y - i_borrow, one bit per clock,
//   LSB first, using a single full-subtractor cell and a registered borrow.
//
// Ports
//   i_clk       clock, all state updates on rising edge
//   i_rst       synchronous reset, active-high, highest priority
//   i_start     request, sampled only while o_ready=1
//   i_x, i_y    minuend / subtrahend, latched on an accepted start
//   i_borrow    borrow-in, latched on an accepted start
//   o_ready     high in IDLE or DONE (a start is accepted)
//   o_busy      high while bits are being processed
//   o_done      one-cycle pulse after the result registers update
//   o_diff      result, held until the next completion
//   o_borrow    unsigned borrow-out, held with o_diff
//   o_overflow  signed overflow, held with o_diff
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_borrow,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Operand sign bits are shifted out of x_q/y_q, so keep copies for the
    // overflow decision at the last bit.
    logic             xmsb_q, xmsb_d;
    logic             ymsb_q, ymsb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    // Full-subtractor cell on bit 0 of the operand shift registers.
    logic d_bit;
    logic b_next;
    assign d_bit  = x_q[0] ^ y_q[0] ^ b_q;
    assign b_next = (~x_q[0] & y_q[0]) | (~(x_q[0] ^ y_q[0]) & b_q);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        res_d    = res_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        xmsb_d   = xmsb_q;
        ymsb_d   = ymsb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    x_d     = i_x;
                    y_d     = i_y;
                    b_d     = i_borrow;
                    cnt_d   = '0;
                    xmsb_d  = i_x[WIDTH-1];
                    ymsb_d  = i_y[WIDTH-1];
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d = {d_bit, res_q[WIDTH-1:1]};
                x_d   = {1'b0, x_q[WIDTH-1:1]};
                y_d   = {1'b0, y_q[WIDTH-1:1]};
                b_d   = b_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Last bit: publish the completed result on this edge.
                    diff_d   = res_d;
                    borrow_d = b_next;
                    ovf_d    = (xmsb_q != ymsb_q) && (d_bit != xmsb_q);
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            res_q    <= '0;
            b_q      <= 1'b0;
            cnt_q    <= '0;
            xmsb_q   <= 1'b0;
            ymsb_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            res_q    <= res_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            xmsb_q   <= xmsb_d;
            ymsb_q   <= ymsb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_ready    = (state_q == IDLE) || (state_q == DONE);
    assign o_busy     = (state_q == RUN);
    assign o_done     = (state_q == DONE);
    assign o_diff     = diff_q;
    assign o_borrow   = borrow_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] x, y;
    logic         bin;
    logic         ready, busy, done;
    logic [W-1:0] diff;
    logic         bout, ovf;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_x(x), .i_y(y),
        .i_borrow(bin), .o_ready(ready), .o_busy(busy), .o_done(done),
        .o_diff(diff), .o_borrow(bout), .o_overflow(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an operation (caller is just past an edge with o_ready=1), checks
    // busy/done timing over the WIDTH run cycles, then the result.
    task automatic run_op(input vec_t v, input string name);
        logic timing_ok;
        start = 1'b1; x = v.x; y = v.y; bin = v.bin;
        tick();
        start = 1'b0; x = $urandom; y = $urandom; bin = 1'b0;
        timing_ok = 1'b1;
        for (int i = 0; i < W - 1; i++) begin
            if (!(busy && !done && !ready)) timing_ok = 1'b0;
            tick();
        end
        if (!(busy && !done)) timing_ok = 1'b0;
        tick();
        chk({name, " timing"}, {31'b0, timing_ok}, 32'd1);
        chk({name, " done"}, {29'b0, done, busy, ready}, 32'b101);
        chk({name, " result"}, {22'b0, diff, bout, ovf}, {22'b0, v.diff, v.bout, v.ovf});
        tick();
        chk({name, " done-drop"}, {30'b0, done, busy}, 32'b0);
    endtask

    vec_t vecs[10];
    vec_t v;
    logic ok;

    initial begin
        vecs[0] = '{8'h5A, 8'h25, 1'b0, 8'h35, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[8] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b1};
        vecs[9] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1};

        // Reset held two cycles with start asserted.
        rst = 1'b1; start = 1'b1; x = 8'h12; y = 8'h34; bin = 1'b1;
        tick();
        tick();
        chk("reset state", {26'b0, ready, busy, done, bout, ovf, 1'b0}, {26'b0, 6'b100000});
        chk("reset diff", {24'b0, diff}, 32'h0);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("post-reset idle", {30'b0, ready, busy}, 32'b10);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Start pulse mid-run must be ignored.
        start = 1'b1; x = 8'h5A; y = 8'h25; bin = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        start = 1'b1; x = 8'hFF; y = 8'h00; bin = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            if (done) ok = 1'b1; else tick();
        end
        chk("midrun done seen", {31'b0, ok}, 32'd1);
        chk("midrun result", {23'b0, diff, bout}, {23'b0, 8'h35, 1'b0});
        tick();
        chk("midrun no restart", {30'b0, busy, done}, 32'b0);

        // Back-to-back: start held across DONE, done every 9 cycles.
        start = 1'b1; x = 8'h80; y = 8'h01; bin = 1'b0;
        tick();
        x = 8'h7F; y = 8'h01;
        for (int i = 0; i < W; i++) tick();
        chk("b2b first done", {21'b0, done, ready, diff, bout, ovf}, {21'b0, 2'b11, 8'h7F, 1'b0, 1'b1});
        tick();
        chk("b2b no bubble", {30'b0, busy, done}, 32'b10);
        start = 1'b0;
        for (int i = 0; i < W; i++) tick();
        chk("b2b second done", {21'b0, done, 1'b0, diff, bout, ovf}, {21'b0, 2'b10, 8'h7E, 1'b0, 1'b0});
        tick();

        // Result holds across idle cycles.
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (diff !== 8'h7E || done || busy) ok = 1'b0;
            tick();
        end
        chk("idle hold", {31'b0, ok}, 32'd1);

        // Reset mid-operation aborts.
        start = 1'b1; x = 8'h5A; y = 8'h25; bin = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort state", {24'b0, diff}, 32'h0);
        chk("abort flags", {28'b0, ready, busy, done, bout}, 32'b1000);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (done || busy) ok = 1'b0;
            tick();
        end
        chk("abort no done", {31'b0, ok}, 32'd1);
        v = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        run_op(v, "after abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
